// File: rtl/alu_calc_sequencer.sv
// Operand/opcode sequencer for the 4-bit calculator ALU: collects A, B and opcode
// tokens, holds them on the ALU for ALU_LAT cycles, then offers the registered result.
module alu_calc_sequencer #(
    parameter int W       = 4,
    parameter int ALU_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [1:0]     alu_op,
    input  logic [2*W-1:0] alu_re,
    output logic [2*W-1:0] res_data,
    output logic [1:0]     res_op,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [7:0]     op_count,
    output logic           busy
);

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        DONE
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);

    state_t     state;
    logic [3:0] lat_cnt;
    logic       in_xfer;
    logic       out_xfer;

    // Handshake qualifiers depend only on the state register (and rst), never on
    // in_valid/res_ready combinationally.
    assign in_ready = !rst && (state == GET_A || state == GET_B || state == GET_OP);
    assign busy     = (state != GET_A);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = res_valid && res_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= GET_A;
            lat_cnt   <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            res_data  <= '0;
            res_op    <= '0;
            res_valid <= 1'b0;
            op_count  <= '0;
        end else if (clr) begin
            state     <= GET_A;
            res_valid <= 1'b0;
        end else begin
            case (state)
                GET_A: begin
                    if (in_xfer) begin
                        alu_a <= in_data;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (in_xfer) begin
                        alu_b <= in_data;
                        state <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (in_xfer) begin
                        alu_op  <= in_data[1:0];
                        lat_cnt <= LAT_LOAD;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (lat_cnt == '0) begin
                        res_data  <= alu_re;
                        res_op    <= alu_op;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (out_xfer) begin
                        res_valid <= 1'b0;
                        op_count  <= op_count + 8'd1;
                        state     <= GET_A;
                    end
                end
                default: state <= GET_A;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_calc_sequencer.sv
// Bench for alu_calc_sequencer: two instances (ALU_LAT=1 and 3) share inputs and are
// checked every cycle against a token/phase-level reference model.
module tb_alu_calc_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;
    logic [3:0] in_data = '0;
    logic in_valid = 1'b0;
    logic res_ready = 1'b0;
    logic [7:0] alu_re = '0;

    logic [1:0]      in_ready_o;
    logic [1:0][3:0] alu_a_o;
    logic [1:0][3:0] alu_b_o;
    logic [1:0][1:0] alu_op_o;
    logic [1:0][7:0] res_data_o;
    logic [1:0][1:0] res_op_o;
    logic [1:0]      res_valid_o;
    logic [1:0][7:0] op_count_o;
    logic [1:0]      busy_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_calc_sequencer #(.W(4), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_o[0]), .alu_a(alu_a_o[0]), .alu_b(alu_b_o[0]), .alu_op(alu_op_o[0]),
        .alu_re(alu_re), .res_data(res_data_o[0]), .res_op(res_op_o[0]),
        .res_valid(res_valid_o[0]), .res_ready(res_ready), .op_count(op_count_o[0]),
        .busy(busy_o[0])
    );

    alu_calc_sequencer #(.W(4), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_o[1]), .alu_a(alu_a_o[1]), .alu_b(alu_b_o[1]), .alu_op(alu_op_o[1]),
        .alu_re(alu_re), .res_data(res_data_o[1]), .res_op(res_op_o[1]),
        .res_valid(res_valid_o[1]), .res_ready(res_ready), .op_count(op_count_o[1]),
        .busy(busy_o[1])
    );

    // stage: 0..2 = tokens collected so far, 3 = waiting on the ALU, 4 = result offered
    typedef struct {
        int stage;
        int elapsed;
        int a, b, op, res, rop, rvalid, count;
    } model_t;

    model_t m [2];
    int lat [2] = '{1, 3};

    typedef struct {
        logic v; logic [3:0] d; logic r; logic [7:0] re;
        logic [3:0] ea; logic [3:0] eb; logic [1:0] eop;
        logic [7:0] eres; logic erv; logic [7:0] ecnt; logic erdy;
    } vec_t;

    vec_t tbl [6];

    function automatic model_t reset_model();
        model_t n;
        n.stage = 0; n.elapsed = 0; n.a = 0; n.b = 0; n.op = 0;
        n.res = 0; n.rop = 0; n.rvalid = 0; n.count = 0;
        return n;
    endfunction

    function automatic model_t step(model_t cur, int latency, logic v, logic [3:0] d,
                                    logic r, logic c, logic [7:0] re);
        model_t n = cur;
        if (c) begin
            n.stage = 0;
            n.rvalid = 0;
            return n;
        end
        if (cur.stage < 3) begin
            if (v) begin
                if (cur.stage == 0) n.a = int'(d);
                else if (cur.stage == 1) n.b = int'(d);
                else n.op = int'(d) % 4;
                n.stage = cur.stage + 1;
                n.elapsed = 0;
            end
        end else if (cur.stage == 3) begin
            n.elapsed = cur.elapsed + 1;
            if (n.elapsed == latency) begin
                n.res = int'(re);
                n.rop = cur.op;
                n.rvalid = 1;
                n.stage = 4;
            end
        end else if (r) begin
            n.rvalid = 0;
            n.count = (cur.count + 1) % 256;
            n.stage = 0;
        end
        return n;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            string s;
            s = $sformatf("lat%0d", lat[i]);
            check({s, ".in_ready"}, 32'(in_ready_o[i]), 32'((m[i].stage < 3) && !rst));
            check({s, ".busy"},     32'(busy_o[i]),     32'(m[i].stage != 0));
            check({s, ".alu_a"},    32'(alu_a_o[i]),    32'(m[i].a));
            check({s, ".alu_b"},    32'(alu_b_o[i]),    32'(m[i].b));
            check({s, ".alu_op"},   32'(alu_op_o[i]),   32'(m[i].op));
            check({s, ".res_data"}, 32'(res_data_o[i]), 32'(m[i].res));
            check({s, ".res_op"},   32'(res_op_o[i]),   32'(m[i].rop));
            check({s, ".res_valid"},32'(res_valid_o[i]),32'(m[i].rvalid));
            check({s, ".op_count"}, 32'(op_count_o[i]), 32'(m[i].count));
        end
    endtask

    task automatic cycle(logic v, logic [3:0] d, logic r, logic c, logic [7:0] re);
        model_t nxt [2];
        in_valid = v; in_data = d; res_ready = r; clr = c; alu_re = re;
        for (int i = 0; i < 2; i++) nxt[i] = step(m[i], lat[i], v, d, r, c, re);
        @(posedge clk);
        #1;
        m = nxt;
        check_all();
    endtask

    initial begin
        logic [7:0] held;
        logic [7:0] cnt_before;
        bit wrapped;

        tbl[0] = '{1'b1, 4'hC, 1'b1, 8'h17, 4'hC, 4'h0, 2'd0, 8'h00, 1'b0, 8'd0, 1'b1};
        tbl[1] = '{1'b1, 4'hB, 1'b1, 8'h17, 4'hC, 4'hB, 2'd0, 8'h00, 1'b0, 8'd0, 1'b1};
        tbl[2] = '{1'b1, 4'h0, 1'b1, 8'h17, 4'hC, 4'hB, 2'd0, 8'h00, 1'b0, 8'd0, 1'b0};
        tbl[3] = '{1'b0, 4'h5, 1'b1, 8'h17, 4'hC, 4'hB, 2'd0, 8'h17, 1'b1, 8'd0, 1'b0};
        tbl[4] = '{1'b0, 4'h5, 1'b1, 8'h17, 4'hC, 4'hB, 2'd0, 8'h17, 1'b0, 8'd1, 1'b1};
        tbl[5] = '{1'b0, 4'h0, 1'b1, 8'h17, 4'hC, 4'hB, 2'd0, 8'h17, 1'b0, 8'd1, 1'b1};

        m[0] = reset_model();
        m[1] = reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all();

        // Basic transaction, ALU_LAT=1 instance checked against the table.
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0, tbl[i].re);
            check($sformatf("tbl%0d.alu_a", i),     32'(alu_a_o[0]),     32'(tbl[i].ea));
            check($sformatf("tbl%0d.alu_b", i),     32'(alu_b_o[0]),     32'(tbl[i].eb));
            check($sformatf("tbl%0d.alu_op", i),    32'(alu_op_o[0]),    32'(tbl[i].eop));
            check($sformatf("tbl%0d.res_data", i),  32'(res_data_o[0]),  32'(tbl[i].eres));
            check($sformatf("tbl%0d.res_valid", i), 32'(res_valid_o[0]), 32'(tbl[i].erv));
            check($sformatf("tbl%0d.op_count", i),  32'(op_count_o[0]),  32'(tbl[i].ecnt));
            check($sformatf("tbl%0d.in_ready", i),  32'(in_ready_o[0]),  32'(tbl[i].erdy));
        end
        repeat (3) cycle(1'b0, 4'h0, 1'b1, 1'b0, 8'h00);

        // Back-pressure in DONE: upstream keeps offering tokens, none accepted.
        cycle(1'b1, 4'h7, 1'b0, 1'b0, 8'h5A);
        cycle(1'b1, 4'h9, 1'b0, 1'b0, 8'h5A);
        cycle(1'b1, 4'h1, 1'b0, 1'b0, 8'h5A);
        repeat (4) cycle(1'b0, 4'h0, 1'b0, 1'b0, 8'h5A);
        held = res_data_o[0];
        cnt_before = op_count_o[0];
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 4'h3, 1'b0, 1'b0, 8'(i));
            check("stall.in_ready", 32'(in_ready_o[0]), 32'd0);
            check("stall.res_data", 32'(res_data_o[0]), 32'h5A);
            check("stall.op_count", 32'(op_count_o[0]), 32'(cnt_before));
        end
        check("stall.held", 32'(held), 32'h5A);
        cycle(1'b0, 4'h0, 1'b1, 1'b0, 8'h00);
        check("release.op_count", 32'(op_count_o[0]), 32'(cnt_before + 8'd1));
        check("release.in_ready", 32'(in_ready_o[0]), 32'd1);

        // ALU_LAT=3: result is the alu_re present at the third edge after the opcode.
        cycle(1'b1, 4'h2, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 4'h6, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 4'h1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 8'h01);
        check("lat3.not_yet", 32'(res_valid_o[1]), 32'd0);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 8'h02);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 8'h03);
        cycle(1'b0, 4'h0, 1'b0, 1'b0, 8'h04);
        check("lat3.res_data", 32'(res_data_o[1]), 32'h03);
        check("lat3.res_valid", 32'(res_valid_o[1]), 32'd1);
        check("lat1.res_data", 32'(res_data_o[0]), 32'h01);
        cycle(1'b0, 4'h0, 1'b1, 1'b0, 8'h00);

        // clr in GET_B (with a competing token), in EXEC, and in DONE alongside res_ready.
        cnt_before = op_count_o[1];
        cycle(1'b1, 4'hA, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 4'hD, 1'b0, 1'b1, 8'h00);
        check("clr_getb.busy", 32'(busy_o[1]), 32'd0);
        check("clr_getb.alu_b", 32'(alu_b_o[1]), 32'h6);
        cycle(1'b1, 4'h8, 1'b0, 1'b0, 8'h00);
        check("clr_getb.next_a", 32'(alu_a_o[1]), 32'h8);
        cycle(1'b1, 4'h4, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 4'h3, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 4'h0, 1'b1, 1'b1, 8'hEE);
        check("clr_exec.res_valid", 32'(res_valid_o[1]), 32'd0);
        check("clr_exec.busy", 32'(busy_o[1]), 32'd0);
        cycle(1'b1, 4'h1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 4'h2, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 4'h3, 1'b0, 1'b0, 8'h00);
        repeat (4) cycle(1'b0, 4'h0, 1'b0, 1'b0, 8'h99);
        cycle(1'b0, 4'h0, 1'b1, 1'b1, 8'h00);
        check("clr_done.res_valid", 32'(res_valid_o[1]), 32'd0);
        check("clr_done.op_count", 32'(op_count_o[1]), 32'(cnt_before));
        check("clr_done.res_data", 32'(res_data_o[1]), 32'h99);

        // Asynchronous reset between edges while in EXEC.
        cycle(1'b1, 4'h5, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 4'h6, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 4'h2, 1'b0, 1'b0, 8'h00);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        m[0] = reset_model();
        m[1] = reset_model();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        #1;
        check_all();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 24) == 0), 8'($urandom));
        end

        // Streaming until the ALU_LAT=1 counter wraps.
        wrapped = 1'b0;
        for (int i = 0; i < 3000 && !wrapped; i++) begin
            int prev;
            prev = m[0].count;
            cycle(1'b1, 4'($urandom), 1'b1, 1'b0, 8'($urandom));
            if (prev == 255 && m[0].count == 0) begin
                wrapped = 1'b1;
                check("wrap.op_count", 32'(op_count_o[0]), 32'd0);
            end
        end
        if (!wrapped) begin
            tests++;
            fails++;
            $display("FAIL wrap.timeout: op_count %0d never wrapped to 0", op_count_o[0]);
        end

        // Opcode token upper bits are ignored.
        cycle(1'b0, 4'h0, 1'b1, 1'b1, 8'h00);
        cycle(1'b1, 4'h1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 4'h2, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 4'hE, 1'b0, 1'b0, 8'h00);
        check("opE.alu_op", 32'(alu_op_o[0]), 32'd2);
        check("opE.alu_op3", 32'(alu_op_o[1]), 32'd2);
        repeat (5) cycle(1'b0, 4'h0, 1'b1, 1'b0, 8'h42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_calc_sequencer.md
# alu_calc_sequencer

Operand/opcode sequencer that sits directly upstream of the 4-bit calculator ALU and also takes in the result it produces. It accepts a serial token stream on a valid/ready input port, in the order operand A, operand B, opcode. It holds `a`, `b` and `op` stable on the ALU inputs and waits a programmable number of cycles. It then registers the ALU's 8-bit result and offers it downstream on a valid/ready output port. It also keeps a running count of completed operations.

## Interface
Parameters:
- `W`, 4: operand width; result width is fixed at 2*W.
- `ALU_LAT`, 1: cycles the ALU inputs are held before `alu_re` is sampled. Legal range 1..15.

Ports:
- `clk`, input, 1: the single clock; everything is rising-edge.
- `rst`, input, 1: reset; asynchronous, active-high.
- `clr`, input, 1: synchronous abort of the operation in progress.
- `in_data`, input, W: token payload; for the opcode token only bits [1:0] are used.
- `in_valid`, input, 1: upstream token valid.
- `in_ready`, output, 1: sequencer can accept a token.
- `alu_a`, output, W: operand A to the ALU.
- `alu_b`, output, W: operand B to the ALU.
- `alu_op`, output, 2: opcode to the ALU.
- `alu_re`, input, 2*W: ALU result.
- `res_data`, output, 2*W: registered result.
- `res_op`, output, 2: opcode that produced `res_data`.
- `res_valid`, output, 1: result available.
- `res_ready`, input, 1: downstream accepts the result.
- `op_count`, output, 8: number of completed operations; wraps 255 -> 0.
- `busy`, output, 1: high in every state except GET_A.

## Operation
- FSM states and transitions:
  - GET_A -> GET_B on an input transfer.
  - GET_B -> GET_OP on an input transfer.
  - GET_OP -> EXEC on an input transfer.
  - EXEC -> DONE after ALU_LAT cycles.
  - DONE -> GET_A on an output transfer.
- An input transfer is `in_valid && in_ready` at a rising edge. An output transfer is `res_valid && res_ready` at a rising edge.
- `in_ready` is 1 only in GET_A, GET_B and GET_OP, and is forced to 0 while `rst` is high.
- The accepted A token loads `alu_a`. The accepted B token loads `alu_b`. The accepted opcode token loads `alu_op` from `in_data[1:0]`; bits above [1:0] are ignored.
- `alu_a`, `alu_b` and `alu_op` change only on their own token transfer. They hold their values through EXEC and DONE, and after DONE until overwritten.
- EXEC uses a down-counter loaded with ALU_LAT-1 on entry. When the counter reaches 0:
  - `alu_re` is captured into `res_data`;
  - `alu_op` is copied into `res_op`;
  - `res_valid` is set and the FSM enters DONE.
- In DONE, `res_data`, `res_op` and `res_valid` hold until an output transfer. On that transfer `res_valid` clears, `op_count` increments and the FSM returns to GET_A.
- `res_data` retains its last value after `res_valid` clears.
- `clr` high at an edge, in any state:
  - the FSM goes to GET_A and `res_valid` clears;
  - no input or output transfer is counted on that edge;
  - `op_count`, `alu_*` and `res_data` are unchanged.
- `clr` takes priority over simultaneous input or output transfers.
- Reset values: state GET_A, `alu_a`=0, `alu_b`=0, `alu_op`=0, `res_data`=0, `res_op`=0, `res_valid`=0, `op_count`=0, `busy`=0.
- Asserting `rst` mid-operation discards the operation immediately, without waiting for a clock edge.

## Timing
- One token is accepted per cycle in the GET states, so back-to-back tokens complete A/B/OP in 3 consecutive edges.
- Let the opcode be accepted at edge k:
  - `alu_op` is valid after edge k;
  - `alu_re` is sampled at edge k+ALU_LAT;
  - `res_valid` is 1 after edge k+ALU_LAT.
- With `in_valid` and `res_ready` held at 1, one operation completes every ALU_LAT+4 cycles.
- `res_ready` may be high before `res_valid` rises; the transfer then occurs on the first edge at which `res_valid` is high.
- In DONE with `res_ready`=0, the FSM stalls indefinitely with outputs stable. `in_ready` stays 0, so upstream tokens are back-pressured and none are lost.
- `in_ready` and `busy` are functions of the state register only; there is no combinational path from `in_valid` or `res_ready`.

## Test plan
- Reset, then send A=4'hC, B=4'hB, op=2'b00 back-to-back, with the bench driving `alu_re`=8'h17 and `res_ready`=1 → `alu_a`=C, `alu_b`=B, `alu_op`=0 after the op edge; `res_data`=8'h17 and `res_op`=0 with `res_valid` for exactly one cycle (ALU_LAT=1); `op_count`=1.
- Hold `res_ready`=0 for 10 cycles in DONE while `in_valid`=1 → `in_ready`=0 throughout, `res_data` stable, `op_count` unchanged; raising `res_ready` → transfer on the next edge, `op_count` increments, `in_ready`=1 the following cycle.
- ALU_LAT=3, `alu_re` changing every cycle (8'h01, 8'h02, 8'h03, …) starting after the op edge → `res_data` equals the value present at edge k+3.
- Assert `clr` in GET_B, in EXEC, and in DONE (with `res_ready`=1 on the same edge) → the FSM returns to GET_A, `res_valid`=0, `op_count` unchanged, and the next A token is accepted normally.
- Assert async `rst` mid-EXEC between clock edges → all outputs reach their reset values immediately; `in_ready`=0 while `rst` is high and 1 after release.
- Complete 256 operations → `op_count` wraps to 0; opcode token `in_data`=4'hE → `alu_op`=2'b10.
